pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline sequencer for the yadan core. It turns per-stage stall requests, the EX branch decision and the instruction-bus handshake into one `stalled_o` vector and one `flush_o` vector, which drive the pc, if_id, id_ex, ex_mem and mem_wb registers. It also owns the PC redirect, including a drain state that discards a wrong-path fetch still outstanding on the AHB instruction port when a branch resolves.

## Interface
- `DRAIN_TIMEOUT`, 255: maximum cycles spent in DRAIN before a forced redirect; minimum 1.
- `clk`  in  1  core clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ex_branch_flag_i`  in  1  taken branch/jump resolved in EX (`BranchEnable`).
- `ex_branch_addr_i`  in  32  branch target.
- `ifetch_ready_i`  in  1  instruction bus data phase complete this cycle.
- `id_stallreq_i`  in  1  load-use hazard in ID.
- `ex_stallreq_i`  in  1  multi-cycle op (div) busy in EX.
- `mem_stallreq_i`  in  1  data bus wait in MEM.
- `stalled_o`  out  5  hold per stage; bit0 pc, bit1 if_id, bit2 id_ex, bit3 ex_mem, bit4 mem_wb.
- `flush_o`  out  5  bubble per stage, same bit order; a set bit loads zeros.
- `pc_redirect_o`  out  1  pc_reg loads `redirect_addr_o` this cycle.
- `redirect_addr_o`  out  32  target PC.
- `fetch_timeout_o`  out  1  sticky error flag; set by a DRAIN timeout.

## Operation
- FSM states: RUN, DRAIN. Registers: state, `tgt_q[31:0]`, `cnt_q[7:0]` (width is clog2(DRAIN_TIMEOUT+1)), `timeout_q`.
- Request priority, evaluated in RUN: mem > ex > branch > id.
- mem_stallreq: stalled = 5'b01111, flush = 5'b10000. The branch is ignored; EX is frozen and the branch is re-presented next cycle.
- ex_stallreq: stalled = 5'b00111, flush = 5'b01000.
- Branch with `ifetch_ready_i`=1: `pc_redirect_o`=1, `redirect_addr_o`=`ex_branch_addr_i`, flush = 5'b00110, stalled = 0. State stays RUN.
- Branch with `ifetch_ready_i`=0:
  - `pc_redirect_o`=0, stalled = 5'b00001, flush = 5'b00110.
  - `tgt_q` <= `ex_branch_addr_i`, `cnt_q` <= 0, next state DRAIN.
- Branch together with id_stallreq: the branch wins and the wrong-path load-use is squashed.
- id_stallreq alone: stalled = 5'b00011, flush = 5'b00100.
- No request: stalled = 0, flush = 0.
- DRAIN, all cycles: stalled[0] = 1, flush[1] = 1. Any returning wrong-path instruction is discarded, and new branches are impossible because id_ex is empty.
- DRAIN, mem/ex stall requests: applied on top of the above by OR of their vectors.
- DRAIN exit on `ifetch_ready_i`=1: `pc_redirect_o`=1, `redirect_addr_o`=`tgt_q`, next state RUN.
- DRAIN otherwise: `cnt_q`++. When `cnt_q` == DRAIN_TIMEOUT-1, force the same exit (redirect, RUN) and set `timeout_q`.
- `redirect_addr_o` = `tgt_q` in DRAIN, else `ex_branch_addr_i`.
- Invariant: if stalled[k]=1 then stalled[j]=1 for all j<k. flush[k] and stalled[k] are never both 1.

## Timing
- Outputs are combinational (Mealy) from inputs and registered state, zero-cycle latency. State changes on `clk` rising edge.
- Reset, `rst`=1 at an edge: state RUN, `cnt_q`=0, `tgt_q`=0, `timeout_q`=0.
- While `rst`=1, outputs are forced: stalled_o=0, flush_o=5'b11111, pc_redirect_o=0, redirect_addr_o=0, fetch_timeout_o=0 (during and after the first reset edge).
- Reset asserted in DRAIN aborts the redirect; no redirect pulse is issued.
- Branch redirect costs 2 bubbles in RUN, and 2 + (bus wait cycles) from DRAIN.
- `fetch_timeout_o` stays 1 until reset.

## Structure
- Add to `yadan_defs.v`:
  - stage indices `STG_PC`..`STG_WB`;
  - state encodings `PC_RUN`, `PC_DRAIN`;
  - vector constants `StallMem`, `StallEx`, `StallId`, `FlushBr`.
- One sub-module, `pipe_drain_timer`: counter plus compare plus sticky flag, with inputs clr, en, and outputs expire, sticky.

## Test plan
- Reset held 3 cycles then released, no requests -> flush_o=5'h1F during reset, then stalled_o=0, flush_o=0, fetch_timeout_o=0.
- id_stallreq 1 cycle -> stalled_o=5'b00011, flush_o=5'b00100; next cycle all 0.
- Branch to 0x0000_0100 with ifetch_ready_i=1 -> same cycle pc_redirect_o=1, redirect_addr_o=0x100, flush_o=5'b00110.
- Branch to 0x200 with ifetch_ready_i=0 for 3 more cycles -> 4 cycles stalled_o[0]=1 and flush_o[1]=1; redirect pulses with 0x200 in the cycle ready returns; then RUN.
- Branch coincident with mem_stallreq, then mem_stallreq drops -> first cycle stalled_o=5'b01111, no redirect; next cycle redirect fires.
- DRAIN_TIMEOUT=4, ifetch_ready_i held 0 -> forced redirect on 4th DRAIN cycle, fetch_timeout_o=1 sticky until rst.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
// Shared definitions for the yadan pipeline sequencer: stage bit indices,
// the sequencer state encoding and the per-request stall/flush vectors.
// Bit k of every stage vector is the register feeding stage k:
//   0 pc, 1 if_id, 2 id_ex, 3 ex_mem, 4 mem_wb.
package pipe_ctrl_pkg;

  localparam int NUM_STG    = 5;
  localparam int STG_PC     = 0;
  localparam int STG_IF_ID  = 1;
  localparam int STG_ID_EX  = 2;
  localparam int STG_EX_MEM = 3;
  localparam int STG_WB     = 4;

  typedef logic [NUM_STG-1:0] stg_vec_t;

  typedef enum logic {
    PC_RUN   = 1'b0,
    PC_DRAIN = 1'b1
  } pc_state_t;

  // A stall request holds its own stage and everything upstream, and
  // injects a bubble into the first stage downstream of the hold.
  localparam stg_vec_t STALL_MEM = 5'b01111;
  localparam stg_vec_t FLUSH_MEM = 5'b10000;
  localparam stg_vec_t STALL_EX  = 5'b00111;
  localparam stg_vec_t FLUSH_EX  = 5'b01000;
  localparam stg_vec_t STALL_ID  = 5'b00011;
  localparam stg_vec_t FLUSH_ID  = 5'b00100;
  localparam stg_vec_t STALL_PC  = 5'b00001;
  // A taken branch squashes the two younger wrong-path instructions.
  localparam stg_vec_t FLUSH_BR  = 5'b00110;
  localparam stg_vec_t FLUSH_ALL = 5'b11111;

endpackage

// File: rtl/pipe_drain_timer.sv
// pipe_drain_timer
// Counts cycles spent waiting in DRAIN and raises a sticky error flag when
// the wait reaches LIMIT cycles.
// Ports:
//   clk, rst  clock and synchronous active-high reset
//   clr       restart the count (entering DRAIN)
//   en        one more cycle waited without the fetch completing
//   expire    this is the LIMIT-th waited cycle; the owner must force an exit
//   sticky    set by an expired wait, cleared only by rst
module pipe_drain_timer #(
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire,
  output logic sticky
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q;
  logic             sticky_q;

  // Purely registered so the owner's combinational logic can consume it
  // without a loop back through en.
  assign expire = (cnt_q == CNT_W'(LIMIT - 1));
  assign sticky = sticky_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      if (clr) begin
        cnt_q <= '0;
      end else if (en) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (en && expire) begin
        sticky_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl
// Pipeline sequencer: merges per-stage stall requests, the EX branch
// decision and the instruction-bus handshake into per-stage hold and
// bubble vectors, and owns the PC redirect. A branch resolving while a
// wrong-path fetch is still outstanding enters DRAIN until the fetch
// completes (or DRAIN_TIMEOUT cycles pass), then redirects.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   ex_branch_flag_i   taken branch/jump resolved in EX
//   ex_branch_addr_i   branch target
//   ifetch_ready_i     instruction bus data phase completes this cycle
//   id/ex/mem_stallreq_i  stall requests from ID, EX, MEM
//   stalled_o          hold per stage (bit0 pc .. bit4 mem_wb)
//   flush_o            bubble per stage, same order
//   pc_redirect_o      pc loads redirect_addr_o this cycle
//   redirect_addr_o    redirect target
//   fetch_timeout_o    sticky DRAIN-timeout error flag
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_branch_flag_i,
  input  logic [31:0] ex_branch_addr_i,
  input  logic        ifetch_ready_i,
  input  logic        id_stallreq_i,
  input  logic        ex_stallreq_i,
  input  logic        mem_stallreq_i,
  output logic [4:0]  stalled_o,
  output logic [4:0]  flush_o,
  output logic        pc_redirect_o,
  output logic [31:0] redirect_addr_o,
  output logic        fetch_timeout_o
);

  pc_state_t   state_q, state_d;
  logic [31:0] tgt_q;
  logic        load_tgt;
  logic        timer_clr, timer_en, timer_expire, timer_sticky;

  pipe_drain_timer #(.LIMIT(DRAIN_TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (timer_clr),
    .en     (timer_en),
    .expire (timer_expire),
    .sticky (timer_sticky)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PC_RUN;
      tgt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (load_tgt) begin
        tgt_q <= ex_branch_addr_i;
      end
    end
  end

  // NOTE: every output of this block is given a default first, so no path
  // through the case/if tree can leave one unassigned and infer a latch.
  always_comb begin
    state_d         = state_q;
    stalled_o       = '0;
    flush_o         = '0;
    pc_redirect_o   = 1'b0;
    redirect_addr_o = ex_branch_addr_i;
    load_tgt        = 1'b0;
    timer_clr       = 1'b0;
    timer_en        = 1'b0;

    if (rst) begin
      // Everything bubbles while in reset; a redirect pending in DRAIN is
      // simply dropped.
      flush_o         = FLUSH_ALL;
      redirect_addr_o = '0;
    end else begin
      unique case (state_q)
        PC_RUN: begin
          if (mem_stallreq_i) begin
            // EX is frozen, so a branch there is simply re-presented later.
            stalled_o = STALL_MEM;
            flush_o   = FLUSH_MEM;
          end else if (ex_stallreq_i) begin
            stalled_o = STALL_EX;
            flush_o   = FLUSH_EX;
          end else if (ex_branch_flag_i) begin
            // Outranks id_stallreq: the load-use sits on the wrong path.
            flush_o = FLUSH_BR;
            if (ifetch_ready_i) begin
              pc_redirect_o = 1'b1;
            end else begin
              // The bus still owes a wrong-path fetch; hold the pc until it
              // lands and remember where to go.
              stalled_o = STALL_PC;
              load_tgt  = 1'b1;
              timer_clr = 1'b1;
              state_d   = PC_DRAIN;
            end
          end else if (id_stallreq_i) begin
            stalled_o = STALL_ID;
            flush_o   = FLUSH_ID;
          end
        end

        PC_DRAIN: begin
          redirect_addr_o           = tgt_q;
          stalled_o[STG_PC]         = 1'b1;
          flush_o[STG_IF_ID]        = 1'b1;
          if (mem_stallreq_i) begin
            stalled_o = stalled_o | STALL_MEM;
            flush_o   = flush_o | FLUSH_MEM;
          end
          if (ex_stallreq_i) begin
            stalled_o = stalled_o | STALL_EX;
            flush_o   = flush_o | FLUSH_EX;
          end
          // A held stage must not also bubble. if_id has carried only
          // zeros since the branch, so holding it discards a returning
          // wrong-path word just as well as flushing it.
          flush_o = flush_o & ~stalled_o;

          if (ifetch_ready_i) begin
            pc_redirect_o = 1'b1;
            state_d       = PC_RUN;
          end else begin
            timer_en = 1'b1;
            if (timer_expire) begin
              pc_redirect_o = 1'b1;
              state_d       = PC_RUN;
            end
          end
        end

        default: state_d = PC_RUN;
      endcase
    end
  end

  assign fetch_timeout_o = rst ? 1'b0 : timer_sticky;

endmodule
